// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel window array.
//   mode_e  : output select (Gx, Gy, |Gx|+|Gy|, edge flag only)
//   grad_w  : signed gradient / magnitude width for a given pixel width
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_GX   = 2'b00,
    MODE_GY   = 2'b01,
    MODE_MAG  = 2'b10,
    MODE_EDGE = 2'b11
  } mode_e;

  // 4*(2^P-1) needs P+2 bits; a signed difference or |Gx|+|Gy| needs P+3.
  function automatic int grad_w(input int pixel_w);
    return pixel_w + 3;
  endfunction

endpackage

// File: rtl/sobel_kernel3x3.sv
// Two-stage Sobel datapath for one 3x3 window.
//   clk, n_rst   : clock, async active-low reset
//   s1_en        : load S1 partial sums from win
//   s2_en        : load S2 result from S1 state
//   win          : 3x3 pixels, win[row][col]
//   mode_s1      : output select captured alongside the S1 sums
//   thr_s1       : edge threshold captured alongside the S1 sums
//   grad         : S2 result (Gx / Gy two's complement, magnitude, or 0)
//   edge_flag    : S2 flag, magnitude >= threshold
module sobel_kernel3x3
  import sobel_pkg::*;
#(
  parameter  int PIXEL_W = 8,
  localparam int GW      = grad_w(PIXEL_W)
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            s1_en,
  input  logic                            s2_en,
  input  logic [2:0][2:0][PIXEL_W-1:0]    win,
  input  mode_e                           mode_s1,
  input  logic [GW-1:0]                   thr_s1,
  output logic [GW-1:0]                   grad,
  output logic                            edge_flag
);

  localparam int SW = PIXEL_W + 2;

  // S1: weighted column sums (for Gx) and row sums (for Gy), all unsigned.
  logic [SW-1:0] left_c, right_c, top_c, bot_c;
  logic [SW-1:0] left_q, right_q, top_q, bot_q;

  always_comb begin
    left_c  = SW'(win[0][0]) + SW'({win[1][0], 1'b0}) + SW'(win[2][0]);
    right_c = SW'(win[0][2]) + SW'({win[1][2], 1'b0}) + SW'(win[2][2]);
    top_c   = SW'(win[0][0]) + SW'({win[0][1], 1'b0}) + SW'(win[0][2]);
    bot_c   = SW'(win[2][0]) + SW'({win[2][1], 1'b0}) + SW'(win[2][2]);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      left_q  <= '0;
      right_q <= '0;
      top_q   <= '0;
      bot_q   <= '0;
    end else if (s1_en) begin
      left_q  <= left_c;
      right_q <= right_c;
      top_q   <= top_c;
      bot_q   <= bot_c;
    end
  end

  // S2: differences, absolute values, select and compare.
  logic [GW-1:0] gx, gy, ax, ay, mag, grad_c;

  always_comb begin
    gx  = {1'b0, right_q} - {1'b0, left_q};
    gy  = {1'b0, bot_q}   - {1'b0, top_q};
    ax  = gx[GW-1] ? (~gx + 1'b1) : gx;
    ay  = gy[GW-1] ? (~gy + 1'b1) : gy;
    mag = ax + ay;                    // at most 8*(2^P-1), never wraps
    case (mode_s1)
      MODE_GX:  grad_c = gx;
      MODE_GY:  grad_c = gy;
      MODE_MAG: grad_c = mag;
      default:  grad_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      grad      <= '0;
      edge_flag <= 1'b0;
    end else if (s2_en) begin
      grad      <= grad_c;
      edge_flag <= (mag >= thr_s1);
    end
  end

endmodule

// File: rtl/sobel_window_array.sv
// NUM_WIN horizontally adjacent 3x3 Sobel windows per beat, two-stage
// valid/ready pipeline, plus a saturating count of delivered edge flags.
//   clk, n_rst    : clock, async active-low reset
//   data_buffer   : 3 x (NUM_WIN+2) pixel strip, element r*(NUM_WIN+2)+c
//   in_valid/in_ready, mode, threshold : input beat
//   grad_out, edge_out, out_valid/out_ready : output beat, window w in slice w
//   clear_count   : synchronous clear of edge_count (wins over increment)
//   edge_count    : saturating popcount of edge_out over output handshakes
module sobel_window_array
  import sobel_pkg::*;
#(
  parameter  int PIXEL_W = 8,
  parameter  int NUM_WIN = 2,
  parameter  int CNT_W   = 16,
  localparam int GW      = grad_w(PIXEL_W),
  localparam int COLS    = NUM_WIN + 2
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic [3*COLS*PIXEL_W-1:0]   data_buffer,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  mode,
  input  logic [GW-1:0]               threshold,
  output logic [NUM_WIN*GW-1:0]       grad_out,
  output logic [NUM_WIN-1:0]          edge_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic                        clear_count,
  output logic [CNT_W-1:0]            edge_count
);

  logic          v1, v2;
  logic          adv1, adv2, s1_en, s2_en;
  mode_e         mode_q;
  logic [GW-1:0] thr_q;

  // A stage advances if it is empty or its consumer takes its contents.
  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign s1_en     = in_valid && adv1;
  assign s2_en     = adv2 && v1;
  assign out_valid = v2;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      mode_q <= MODE_GX;
      thr_q  <= '0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
      if (s1_en) begin
        mode_q <= mode_e'(mode);
        thr_q  <= threshold;
      end
    end
  end

  for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
    logic [2:0][2:0][PIXEL_W-1:0] win;
    for (genvar r = 0; r < 3; r++) begin : g_row
      for (genvar c = 0; c < 3; c++) begin : g_col
        assign win[r][c] = data_buffer[(r*COLS + w + c)*PIXEL_W +: PIXEL_W];
      end
    end

    sobel_kernel3x3 #(.PIXEL_W(PIXEL_W)) u_kernel (
      .clk       (clk),
      .n_rst     (n_rst),
      .s1_en     (s1_en),
      .s2_en     (s2_en),
      .win       (win),
      .mode_s1   (mode_q),
      .thr_s1    (thr_q),
      .grad      (grad_out[w*GW +: GW]),
      .edge_flag (edge_out[w])
    );
  end

  // Per-flag saturating increment keeps the sum from ever wrapping.
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = edge_count;
    if (out_valid && out_ready) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        if (edge_out[w] && (cnt_nxt != {CNT_W{1'b1}})) cnt_nxt = cnt_nxt + 1'b1;
      end
    end
    if (clear_count) cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) edge_count <= '0;
    else        edge_count <= cnt_nxt;
  end

endmodule

// File: tb/tb_sobel_window_array.sv
module tb_sobel_window_array;

  localparam int PW = 8;
  localparam int NW = 2;
  localparam int CW = 4;
  localparam int GW = 11;
  localparam int DW = 3 * (NW + 2) * PW;

  logic              clk;
  logic              n_rst;
  logic [DW-1:0]     data_buffer;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        mode;
  logic [GW-1:0]     threshold;
  logic [NW*GW-1:0]  grad_out;
  logic [NW-1:0]     edge_out;
  logic              out_valid;
  logic              out_ready;
  logic              clear_count;
  logic [CW-1:0]     edge_count;

  sobel_window_array #(.PIXEL_W(PW), .NUM_WIN(NW), .CNT_W(CW)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .data_buffer (data_buffer),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mode        (mode),
    .threshold   (threshold),
    .grad_out    (grad_out),
    .edge_out    (edge_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .clear_count (clear_count),
    .edge_count  (edge_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NW*GW-1:0] grad;
    logic [NW-1:0]    edg;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   in_rst  = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat_cols(input logic [7:0] c0, input logic [7:0] c1,
                                              input logic [7:0] c2, input logic [7:0] c3);
    logic [DW-1:0] d;
    logic [7:0]    cv[4];
    cv = '{c0, c1, c2, c3};
    d  = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) d[(r*4 + c)*8 +: 8] = cv[c];
    return d;
  endfunction

  function automatic logic [DW-1:0] pat_rows(input logic [7:0] r0, input logic [7:0] r1,
                                              input logic [7:0] r2);
    logic [DW-1:0] d;
    logic [7:0]    rv[3];
    rv = '{r0, r1, r2};
    d  = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) d[(r*4 + c)*8 +: 8] = rv[r];
    return d;
  endfunction

  // Drive one beat, wait (bounded) for the handshake, push the expectation.
  task automatic send(input logic [DW-1:0] d, input logic [1:0] md, input logic [GW-1:0] thr,
                      input logic [GW-1:0] g0, input logic [GW-1:0] g1, input logic [1:0] e);
    int t;
    data_buffer = d;
    mode        = md;
    threshold   = thr;
    in_valid    = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      q.push_back('{grad: {g1, g0}, edg: e});
      #1 in_valid = 1'b0;
    end
  endtask

  // Monitor: compare every output handshake against the scoreboard and
  // check that a stalled output holds still.
  initial begin
    exp_t             e;
    bit               held;
    logic [NW*GW-1:0] h_grad;
    logic [NW-1:0]    h_edge;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (in_rst || !n_rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_grad", 32'(grad_out), 32'(h_grad));
          check("hold_edge", 32'(edge_out), 32'(h_edge));
        end
        held   = out_valid && !out_ready;
        h_grad = grad_out;
        h_edge = edge_out;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check("grad", 32'(grad_out), 32'(e.grad));
            check("edge", 32'(edge_out), 32'(e.edg));
          end
        end
      end
    end
  end

  initial begin
    n_rst       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    clear_count = 1'b0;
    mode        = 2'b00;
    threshold   = '0;
    data_buffer = '0;

    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_grad", 32'(grad_out), 32'd0);
    check("rst_edge", 32'(edge_out), 32'd0);
    check("rst_count", 32'(edge_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    in_rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Flat image, latency check.
    send(pat_cols(100, 100, 100, 100), 2'b10, 11'd1, 11'd0, 11'd0, 2'b00);
    @(negedge clk);
    check("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Vertical step 100|200: Gx = 400, Gy = 0.
    send(pat_cols(100, 100, 200, 200), 2'b00, 11'd500, 11'd400, 11'd400, 2'b00);
    send(pat_cols(100, 100, 200, 200), 2'b01, 11'd500, 11'd0,   11'd0,   2'b00);
    send(pat_cols(100, 100, 200, 200), 2'b10, 11'd400, 11'd400, 11'd400, 2'b11);
    // Opposite step: Gx = -400 = 11'h670.
    send(pat_cols(200, 200, 100, 100), 2'b00, 11'd400, 11'h670, 11'h670, 2'b11);
    // Horizontal step 0 / 255 / 255: Gy = 1020.
    send(pat_rows(0, 255, 255), 2'b01, 11'd1020, 11'd1020, 11'd1020, 2'b11);
    // Single bright left column: window 0 Gx = -1020, window 1 flat.
    send(pat_cols(255, 0, 0, 0), 2'b00, 11'd1020, 11'h404, 11'd0, 2'b01);
    // Edge-only mode: grad forced to zero, flag still computed.
    send(pat_rows(0, 255, 255), 2'b11, 11'd1021, 11'd0, 11'd0, 2'b00);
    send(pat_rows(0, 255, 255), 2'b11, 11'd1000, 11'd0, 11'd0, 2'b11);
    repeat (4) @(posedge clk); #1;
    check("drain1", 32'(q.size()), 32'd0);

    // Ten back-to-back beats, output stalled for four cycles.
    fork
      begin
        for (int k = 0; k < 10; k++)
          send(pat_cols(10, 10, 8'(10 + 5*k), 8'(10 + 5*k)), 2'b00, 11'd100,
               11'(20*k), 11'(20*k), (k >= 5) ? 2'b11 : 2'b00);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;
    check("drain2", 32'(q.size()), 32'd0);

    // Counter saturation at 15 (CNT_W = 4).
    clear_count = 1'b1;
    @(posedge clk); #1 clear_count = 1'b0;
    @(negedge clk);
    check("count_clear", 32'(edge_count), 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 7; k++)
      send(pat_rows(0, 255, 255), 2'b01, 11'd1020, 11'd1020, 11'd1020, 2'b11);
    send(pat_cols(255, 0, 0, 0), 2'b00, 11'd1020, 11'h404, 11'd0, 2'b01);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("count_15", 32'(edge_count), 32'd15);
    @(posedge clk); #1;
    send(pat_rows(0, 255, 255), 2'b01, 11'd1020, 11'd1020, 11'd1020, 2'b11);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("count_sat", 32'(edge_count), 32'd15);
    @(posedge clk); #1;

    // Clear coinciding with an edge-carrying output handshake.
    out_ready = 1'b0;
    send(pat_rows(0, 255, 255), 2'b01, 11'd1020, 11'd1020, 11'd1020, 2'b11);
    repeat (2) @(posedge clk);
    #1;
    clear_count = 1'b1;
    out_ready   = 1'b1;
    @(posedge clk); #1 clear_count = 1'b0;
    @(negedge clk);
    check("clear_vs_inc", 32'(edge_count), 32'd0);
    @(posedge clk); #1;

    // Reset with both stages full.
    out_ready = 1'b0;
    send(pat_cols(100, 100, 200, 200), 2'b00, 11'd1, 11'd400, 11'd400, 2'b11);
    send(pat_cols(100, 100, 200, 200), 2'b00, 11'd1, 11'd400, 11'd400, 2'b11);
    in_rst = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_grad", 32'(grad_out), 32'd0);
    check("midrst_edge", 32'(edge_out), 32'd0);
    check("midrst_count", 32'(edge_count), 32'd0);
    q.delete();
    @(posedge clk); #1;
    n_rst     = 1'b1;
    in_rst    = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("no_stale", 32'(out_valid), 32'd0);
    end
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("final_queue", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_window_array.md
SOBEL_WINDOW_ARRAY -- requirements
Module: sobel_window_array

Interface
REQ-001 Parameter PIXEL_W, default 8: unsigned pixel width in bits.
REQ-002 Parameter NUM_WIN, default 2: number of horizontally adjacent 3x3 windows computed per beat.
REQ-003 Parameter CNT_W, default 16: width of the edge counter.
REQ-004 The block SHALL have one clock, clk, and one asynchronous active-low reset, n_rst.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 n_rst  in  1  asynchronous active-low reset.
REQ-007 data_buffer  in  3*(NUM_WIN+2)*PIXEL_W  3-row pixel strip; element index r*(NUM_WIN+2)+c, row 0 at the top, column 0 at the left.
REQ-008 in_valid  in  1  data_buffer, mode and threshold are valid this cycle.
REQ-009 in_ready  out  1  block accepts input this cycle.
REQ-010 mode  in  2  00 Gx, 01 Gy, 10 |Gx|+|Gy|, 11 edge flag only.
REQ-011 threshold  in  PIXEL_W+3  edge threshold, unsigned.
REQ-012 grad_out  out  NUM_WIN*(PIXEL_W+3)  per-window result; window w occupies slice w.
REQ-013 edge_out  out  NUM_WIN  per-window edge flag.
REQ-014 out_valid  out  1  grad_out/edge_out are valid.
REQ-015 out_ready  in  1  downstream accepts output.
REQ-016 clear_count  in  1  synchronous clear of edge_count.
REQ-017 edge_count  out  CNT_W  saturating count of asserted edge flags accepted downstream.

Function
REQ-018 Window w SHALL use columns w..w+2 of all three rows.
REQ-019 Gx SHALL equal (p[0][2]+2p[1][2]+p[2][2]) - (p[0][0]+2p[1][0]+p[2][0]), computed signed in PIXEL_W+3 bits without overflow.
REQ-020 Gy SHALL equal (p[2][0]+2p[2][1]+p[2][2]) - (p[0][0]+2p[0][1]+p[0][2]), computed signed in PIXEL_W+3 bits.
REQ-021 The magnitude SHALL be |Gx|+|Gy|, unsigned in PIXEL_W+3 bits, exact with no saturation (max 8*(2^PIXEL_W-1)).
REQ-022 grad_out SHALL carry Gx (mode 00), Gy (01), magnitude (10), or zero (11), two's complement for 00/01.
REQ-023 edge_out[w] SHALL be 1 if and only if the magnitude is greater than or equal to threshold, for every mode.
REQ-024 The pipeline SHALL have two register stages: S1 (column/row partial sums, mode and threshold captured) and S2 (final sums, select, compare); latency is 2 cycles from input handshake to out_valid when unstalled.
REQ-025 Input handshake occurs when in_valid&&in_ready; output handshake occurs when out_valid&&out_ready.
REQ-026 S2 SHALL advance when S2 is empty or out_ready=1; S1 SHALL advance when S1 is empty or S2 advances; in_ready SHALL equal the S1-advance condition and be combinational from out_ready.
REQ-027 While out_valid=1 and out_ready=0, grad_out, edge_out and out_valid SHALL hold stable; no beat is dropped or duplicated.
REQ-028 Throughput SHALL be one beat per cycle when in_valid and out_ready are continuously 1.
REQ-029 mode and threshold SHALL be captured per beat at input handshake; a change applies only to later beats.
REQ-030 On each output handshake, edge_count SHALL add popcount(edge_out), saturating at 2^CNT_W-1.
REQ-031 If clear_count=1, edge_count SHALL become 0 in the next cycle, overriding a simultaneous increment.

Reset
REQ-032 With n_rst low, S1/S2 valid flags, out_valid, grad_out, edge_out and edge_count SHALL be 0 immediately; in_ready SHALL be 1 after reset release.
REQ-033 A reset mid-operation SHALL discard in-flight beats; no output appears for them.

Structure
REQ-034 Package sobel_pkg SHALL hold the mode enum (MODE_GX, MODE_GY, MODE_MAG, MODE_EDGE) and the grad-width function PIXEL_W+3.
REQ-035 One sub-module, sobel_kernel3x3, SHALL compute the S1/S2 datapath for a single window and be instantiated NUM_WIN times via generate.

Verification (PIXEL_W=8, NUM_WIN=2)
REQ-036 All pixels 100, mode 10, threshold 1 -> grad_out {0,0}, edge_out 00, out_valid 2 cycles after handshake.
REQ-037 Columns 0-1 = 100, columns 2-3 = 200, mode 00 -> Gx 400 in both windows; mode 01 -> 0; mode 10, threshold 400 -> edge_out 11.
REQ-038 Row 0 = 0, rows 1-2 = 255, mode 01 -> Gy 1020 in both windows; column 0 = 255, others 0, mode 00 -> window 0 Gx -1020 (11'h404), window 1 Gx 0.
REQ-039 Ten back-to-back beats, with out_ready low for cycles 3-6 -> all ten results delivered in order, held stable during the stall, in_ready low once both stages are full.
REQ-040 edge_count: preload near saturation (CNT_W=4, 15 edges) then one more edge -> stays 15; clear_count with a simultaneous edge -> 0.
REQ-041 n_rst asserted with both stages full -> out_valid 0 immediately, no stale output after release.
